// File: rtl/ghost_collision_monitor_pkg.sv
// ghost_collision_monitor_pkg
// Shared playfield geometry and FSM state encodings for the ghost collision monitor.
// Mirrors the tile constants in define.v: a 640x480 playfield on a 20-pixel tile grid.
// Contents:
//   TILE, WIDTH, HEIGHT       playfield geometry in pixels
//   width_log2, height_log2   coordinate widths for x and y
//   y_pad                     zero bits needed to widen a y value to width_log2
//   gcm_state_e               collision monitor FSM states (gcm_idle .. gcm_over)
package ghost_collision_monitor_pkg;

    localparam int unsigned TILE        = 20;
    localparam int unsigned WIDTH       = 640;
    localparam int unsigned HEIGHT      = 480;
    localparam int unsigned width_log2  = $clog2(WIDTH);
    localparam int unsigned height_log2 = $clog2(HEIGHT);
    localparam int unsigned y_pad       = width_log2 - height_log2;

    typedef enum logic [2:0] {
        gcm_idle    = 3'd0,
        gcm_play    = 3'd1,
        gcm_hit     = 3'd2,
        gcm_frozen  = 3'd3,
        gcm_respawn = 3'd4,
        gcm_over    = 3'd5
    } gcm_state_e;

endpackage

// File: rtl/ghost_hit_compare.sv
// ghost_hit_compare
// Combinational catch test for a single ghost against the player.
// Ports:
//   player_x/y        current player position
//   player_prev_x/y   player position registered one cycle earlier
//   ghost_x/y         current ghost position
//   ghost_prev_x/y    ghost position registered one cycle earlier
//   swap_enable       allows the swap test (low while previous copies are stale)
//   hit               overlap, or (when enabled) player and ghost stepped through each other
module ghost_hit_compare
    import ghost_collision_monitor_pkg::*;
(
    input  logic [width_log2-1:0]  player_x,
    input  logic [width_log2-1:0]  player_y,
    input  logic [width_log2-1:0]  player_prev_x,
    input  logic [width_log2-1:0]  player_prev_y,
    input  logic [width_log2-1:0]  ghost_x,
    input  logic [height_log2-1:0] ghost_y,
    input  logic [width_log2-1:0]  ghost_prev_x,
    input  logic [height_log2-1:0] ghost_prev_y,
    input  logic                   swap_enable,
    output logic                   hit
);

    logic [width_log2-1:0] ghost_y_ext;
    logic [width_log2-1:0] ghost_prev_y_ext;
    logic                  overlap;
    logic                  swap;
    logic                  player_moved;

    // Ghost y is narrower than player y; widen so the compare is exact at full width.
    assign ghost_y_ext      = {{y_pad{1'b0}}, ghost_y};
    assign ghost_prev_y_ext = {{y_pad{1'b0}}, ghost_prev_y};

    always_comb begin
        overlap      = (ghost_x == player_x) && (ghost_y_ext == player_y);
        player_moved = (player_x != player_prev_x) || (player_y != player_prev_y);
        swap         = swap_enable && player_moved
                       && (ghost_x == player_prev_x) && (ghost_y_ext == player_prev_y)
                       && (player_x == ghost_prev_x) && (player_y == ghost_prev_y_ext);
        hit          = overlap || swap;
    end

endmodule

// File: rtl/ghost_collision_monitor.sv
// ghost_collision_monitor
// Detects when a ghost catches the player and runs the life / freeze / respawn sequence.
// Ports:
//   clk, reset         system clock, synchronous active-high reset
//   start              level-sensitive start/restart, honoured only in IDLE and OVER
//   player_x/y         player tile origin in pixels
//   ghost_x_bus/y_bus  packed ghost positions, ghost i in slice i
//   freeze             movement controllers hold position while high
//   respawn            one-cycle pulse: controllers reload home positions
//   caught             one-cycle pulse on a catch
//   caught_ghost_id    lowest-index catching ghost, held until the next catch or restart
//   lives              remaining lives
//   game_over          high while in OVER
// All outputs are registered from the next-state decode.
module ghost_collision_monitor
    import ghost_collision_monitor_pkg::*;
#(
    parameter int unsigned NUM_GHOSTS    = 4,
    parameter int unsigned LIVES_INIT    = 3,
    parameter int unsigned FREEZE_CYCLES = 25_000_000
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             start,
    input  logic [width_log2-1:0]            player_x,
    input  logic [width_log2-1:0]            player_y,
    input  logic [NUM_GHOSTS*width_log2-1:0] ghost_x_bus,
    input  logic [NUM_GHOSTS*height_log2-1:0] ghost_y_bus,
    output logic                             freeze,
    output logic                             respawn,
    output logic                             caught,
    output logic [1:0]                       caught_ghost_id,
    output logic [1:0]                       lives,
    output logic                             game_over
);

    localparam int unsigned CNT_W = $clog2(FREEZE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FREEZE_CYCLES - 1);

    gcm_state_e state_q, state_d;
    logic [CNT_W-1:0]                  cnt_q;
    logic [width_log2-1:0]             player_prev_x_q, player_prev_y_q;
    logic [NUM_GHOSTS*width_log2-1:0]  ghost_prev_x_q;
    logic [NUM_GHOSTS*height_log2-1:0] ghost_prev_y_q;
    logic                              first_play_q;
    logic [NUM_GHOSTS-1:0]             hit;
    logic [1:0]                        hit_id;
    logic                              restart;

    for (genvar g = 0; g < NUM_GHOSTS; g++) begin : g_cmp
        ghost_hit_compare u_cmp (
            .player_x      (player_x),
            .player_y      (player_y),
            .player_prev_x (player_prev_x_q),
            .player_prev_y (player_prev_y_q),
            .ghost_x       (ghost_x_bus[g*width_log2 +: width_log2]),
            .ghost_y       (ghost_y_bus[g*height_log2 +: height_log2]),
            .ghost_prev_x  (ghost_prev_x_q[g*width_log2 +: width_log2]),
            .ghost_prev_y  (ghost_prev_y_q[g*height_log2 +: height_log2]),
            // Previous copies still hold pre-reload positions on the first PLAY cycle.
            .swap_enable   (!first_play_q),
            .hit           (hit[g])
        );
    end

    // Lowest index wins: scan downwards so the last assignment is the smallest hit.
    always_comb begin
        hit_id = 2'd0;
        for (int i = NUM_GHOSTS - 1; i >= 0; i--) begin
            if (hit[i]) hit_id = 2'(i);
        end
    end

    always_comb begin
        state_d = state_q;
        restart = 1'b0;
        unique case (state_q)
            gcm_idle:    if (start) state_d = gcm_play;
            gcm_play:    if (|hit) state_d = gcm_hit;
            gcm_hit:     state_d = gcm_frozen;
            gcm_frozen: begin
                if (cnt_q == CNT_LAST) begin
                    state_d = (lives == 2'd0) ? gcm_over : gcm_respawn;
                end
            end
            gcm_respawn: state_d = gcm_play;
            gcm_over: begin
                if (start) begin
                    state_d = gcm_play;
                    restart = 1'b1;
                end
            end
            default:     state_d = gcm_idle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q         <= gcm_idle;
            cnt_q           <= '0;
            player_prev_x_q <= '0;
            player_prev_y_q <= '0;
            ghost_prev_x_q  <= '0;
            ghost_prev_y_q  <= '0;
            first_play_q    <= 1'b0;
            freeze          <= 1'b1;
            respawn         <= 1'b0;
            caught          <= 1'b0;
            game_over       <= 1'b0;
            caught_ghost_id <= 2'd0;
            lives           <= 2'(LIVES_INIT);
        end else begin
            state_q         <= state_d;
            player_prev_x_q <= player_x;
            player_prev_y_q <= player_y;
            ghost_prev_x_q  <= ghost_x_bus;
            ghost_prev_y_q  <= ghost_y_bus;
            first_play_q    <= (state_d == gcm_play) && (state_q != gcm_play);
            // Counts only while staying in FROZEN; it leaves at CNT_LAST so it never wraps.
            cnt_q           <= (state_q == gcm_frozen && state_d == gcm_frozen) ?
                               cnt_q + 1'b1 : '0;
            freeze          <= (state_d != gcm_play);
            respawn         <= (state_d == gcm_respawn) || restart;
            caught          <= (state_d == gcm_hit);
            game_over       <= (state_d == gcm_over);
            if (state_q == gcm_play && |hit) begin
                caught_ghost_id <= hit_id;
            end else if (restart) begin
                caught_ghost_id <= 2'd0;
            end
            if (state_q == gcm_hit) begin
                lives <= (lives == 2'd0) ? 2'd0 : lives - 2'd1;
            end else if (restart) begin
                lives <= 2'(LIVES_INIT);
            end
        end
    end

endmodule

// File: doc/ghost_collision_monitor.md
# ghost_collision_monitor

Consumes the per-ghost `x`/`y` outputs of the four ghost movement controllers, plus the player position, and decides when the player is caught. It runs the life and respawn sequence and drives `freeze`/`respawn` back to the movement controllers and the player controller. It sits between the movement controllers and the top-level game logic/renderer, on the 20-pixel tile grid defined in `define.v`.

## Interface
- `NUM_GHOSTS`, 4, number of ghost position inputs (1..4).
- `LIVES_INIT`, 3, lives loaded at reset and on restart (1..3).
- `FREEZE_CYCLES`, 25_000_000, cycles the playfield stays frozen after a catch (≥2).

- `clk` in 1: system clock.
- `reset` in 1: synchronous, active-high reset.
- `start` in 1: level-sensitive start/restart request, sampled each cycle.
- `player_x` in `width_log2`: player tile origin x, in pixels.
- `player_y` in `width_log2`: player tile origin y, in pixels.
- `ghost_x_bus` in `NUM_GHOSTS*$clog2(WIDTH)`: ghost x values; ghost i occupies slice i.
- `ghost_y_bus` in `NUM_GHOSTS*$clog2(HEIGHT)`: ghost y values; ghost i occupies slice i.
- `freeze` out 1: movement controllers must hold position while this is high.
- `respawn` out 1: one-cycle pulse; controllers reload their home position.
- `caught` out 1: one-cycle pulse on a catch.
- `caught_ghost_id` out 2: index of the catching ghost. Held until the next catch.
- `lives` out 2: remaining lives.
- `game_over` out 1: high while in state OVER.

## Operation
- FSM states are IDLE, PLAY, HIT, FROZEN, RESPAWN and OVER.
- IDLE: `freeze`=1. `start`=1 moves the FSM to PLAY.
- PLAY: collisions are checked every cycle. `freeze`=0. Any hit moves the FSM to HIT.
- HIT: lasts exactly one cycle.
  - `caught`=1 and `freeze`=1.
  - `caught_ghost_id` is latched.
  - `lives` decrements at the end of HIT and saturates at 0.
  - Next state is FROZEN.
- FROZEN: `freeze`=1 and a counter runs for FREEZE_CYCLES cycles.
  - When the counter expires with `lives`==0, the FSM goes to OVER.
  - Otherwise it goes to RESPAWN.
- RESPAWN: lasts one cycle with `respawn`=1 and `freeze`=1. Next state is PLAY.
- OVER: `game_over`=1 and `freeze`=1.
  - `start`=1 reloads `lives`=LIVES_INIT, clears `caught_ghost_id`, pulses `respawn` in the same cycle, and moves the FSM to PLAY.
- Hit definition for ghost i, using the current inputs and a copy of every position registered one cycle earlier:
  - overlap: `ghost_x`==`player_x` && `ghost_y`==`player_y`;
  - OR swap: `ghost_now`==`player_prev` && `player_now`==`ghost_prev`, with `player_now`!=`player_prev`.
- Swap detection covers the case where the player and a ghost step through each other on the same clock edge. Moves on different edges always produce an overlap cycle.
- Swap is masked in the first PLAY cycle after IDLE, RESPAWN or OVER, because the previous-position copies are stale after the home reload. Overlap is never masked.
- Priority when several ghosts hit in the same cycle: the lowest index wins `caught_ghost_id`.
- Outside PLAY, hits are ignored and `start` is ignored. `start` is acted on only in IDLE and OVER.
- Compares are exact equality at full width; there is no tile rounding.
- Unused ghost slices (index ≥ NUM_GHOSTS) do not exist.

## Timing
- Reset values:
  - state IDLE;
  - `freeze`=1, `respawn`=0, `caught`=0, `game_over`=0;
  - `caught_ghost_id`=0, `lives`=LIVES_INIT;
  - counter 0, previous-position registers 0.
- Reset asserted in any state, including mid-FROZEN, takes effect at the next edge and overrides everything.
- All outputs are registered. Detection latency is 1 cycle: a hit on inputs in cycle n gives `caught`=1 and `freeze`=1 in cycle n+1. The decremented `lives` is visible from n+2.
- `freeze` stays high from n+1 through the RESPAWN cycle, which is cycle n+2+FREEZE_CYCLES. `freeze` is 0 from the next cycle.
- IDLE→PLAY: `freeze` falls the cycle after `start` is sampled.
- Counter width is `$clog2(FREEZE_CYCLES+1)`. The counter clears on entry to FROZEN and never wraps.

## Structure
- Add the FSM state encodings (`gcm_idle` … `gcm_over`, 3 bits) to `define.v` beside the `dir_*` and tile constants.
- Sub-module `ghost_hit_compare`: purely combinational overlap and swap test for one ghost, instantiated NUM_GHOSTS times under a generate loop. The top level holds the registers, the priority encoder and the FSM.

## Test plan
- Overlap: after `start`, drive ghost 2 to (200,320) while the player is at (200,320) in cycle n.
  - Required: `caught`=1 and `caught_ghost_id`=2 at n+1; `lives` 3→2 at n+2.
- Swap: the player moves (180,160)→(200,160) while ghost 0 moves (200,160)→(180,160) on the same edge.
  - Required: a catch with id 0. The same moves on edges 3 cycles apart must also catch, via overlap.
- Simultaneous hit: ghosts 1 and 3 both overlap the player in one cycle.
  - Required: `caught_ghost_id`=1 and a single `caught` pulse.
- Respawn timing: with FREEZE_CYCLES=5, one catch.
  - Required: `freeze` high for 7 cycles; `respawn` a single pulse in the last of those cycles; no second catch while ghosts stay on the player during FROZEN.
- Game over and restart: three catches, then `game_over`=1 and `lives`=0.
  - Required: hits ignored while `game_over`=1; `start` gives `lives`=3, a `respawn` pulse and PLAY.
- Mid-FROZEN reset: assert `reset` in cycle 2 of FROZEN.
  - Required: state IDLE, `lives`=3, `freeze`=1, `respawn`=0 the next cycle; `caught` is never pulsed again.
